// File: rtl/struc_adder_full_adder.sv
// full_adder: single-bit full-adder cell expressed with gate-level operators
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/struc_adder.sv
// struc_adder: SIZE-bit ripple-carry adder of full_adder cells with registered sum and carry-out
module struc_adder #(
    parameter int SIZE = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [SIZE-1:0] dinx_i,
    input  logic [SIZE-1:0] diny_i,
    output logic [SIZE-1:0] sum_o,
    output logic            cout_o
);
    logic [SIZE:0]   c;
    logic [SIZE-1:0] s;
    logic [SIZE-1:0] sum_d, sum_q;
    logic            cout_d, cout_q;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < SIZE; i++) begin : g_fa
        full_adder u_fa (
            .a   (dinx_i[i]),
            .b   (diny_i[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end
    always_comb begin
        sum_d  = s;
        cout_d = c[SIZE];
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
endmodule

// File: tb/tb_struc_adder.sv
// tb_struc_adder: directed and random checks of struc_adder at SIZE 4, 16 and 1 against x+y
module tb_struc_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  x4 = '0, y4 = '0, s4;
    logic [15:0] x16 = '0, y16 = '0, s16;
    logic        x1 = 1'b0, y1 = 1'b0, s1;
    logic        c4, c16, c1;
    logic [16:0] e4, e16, e1;
    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    struc_adder #(.SIZE(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .dinx_i(x4), .diny_i(y4), .sum_o(s4), .cout_o(c4)
    );
    struc_adder #(.SIZE(16)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .dinx_i(x16), .diny_i(y16), .sum_o(s16), .cout_o(c16)
    );
    struc_adder #(.SIZE(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .dinx_i(x1), .diny_i(y1), .sum_o(s1), .cout_o(c1)
    );

    task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s got %h expected %h", tag, obs, exp);
    endtask

    // Drive one set of operands; before the edge the outputs must still show the previous
    // result (no combinational path), one edge later they must show the new sum.
    task automatic cycle(input string tag, input logic [3:0] a4, b4, input logic [15:0] a16, b16,
                         input logic a1, b1, input bit r, input bit hold);
        @(negedge clk);
        x4 = a4; y4 = b4; x16 = a16; y16 = b16; x1 = a1; y1 = b1; rst = r;
        #1;
        if (hold) begin
            check({tag, "/hold4"}, {12'd0, c4, s4}, e4);
            check({tag, "/hold16"}, {c16, s16}, e16);
            check({tag, "/hold1"}, {15'd0, c1, s1}, e1);
        end
        @(posedge clk);
        #1;
        e4  = r ? 17'd0 : 17'(a4) + 17'(b4);
        e16 = r ? 17'd0 : 17'(a16) + 17'(b16);
        e1  = r ? 17'd0 : 17'(a1) + 17'(b1);
        check({tag, "/sum4"}, {12'd0, c4, s4}, e4);
        check({tag, "/sum16"}, {c16, s16}, e16);
        check({tag, "/sum1"}, {15'd0, c1, s1}, e1);
    endtask

    initial begin
        cycle("reset0", 4'h5, 4'h6, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle("reset1", 4'hF, 4'hF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle("wrap", 4'hF, 4'h1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
        cycle("plain", 4'h3, 4'h4, 16'h1234, 16'h0F0F, 1'b0, 1'b1, 1'b0, 1'b1);
        cycle("zero", 4'h0, 4'h0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("ones", 4'hF, 4'hF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++)
            cycle("stream", 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b1);
        cycle("midrst", 4'h9, 4'h8, 16'h8000, 16'h8001, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle("afterrst", 4'h9, 4'h8, 16'h8000, 16'h8001, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 256; k++)
            cycle("exh", 4'(k >> 4), 4'(k), 16'($urandom), 16'($urandom),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, 1'b1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
